// File: rtl/ccm_ctr_block_gen.sv
// CCM counter-block generator: issues {flag, nonce, count} blocks to an AES core
// on request and forwards the resulting ciphertext as keystream blocks.
module ccm_ctr_block_gen #(
    parameter int  WIDTH_NONCE = 100,
    parameter int  WIDTH_FLAG  = 8,
    parameter int  WIDTH_COUNT = 20,
    localparam int WIDTH_KEY   = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT
) (
    input  logic                   clk,
    input  logic                   kill,
    input  logic                   start,
    input  logic [WIDTH_NONCE-1:0] nonce,
    input  logic [WIDTH_FLAG-1:0]  flag,
    input  logic                   block_req,
    input  logic                   last_in,
    input  logic                   aes_ready,
    input  logic [WIDTH_KEY-1:0]   aes_out_data,
    input  logic                   aes_out_en,
    output logic [WIDTH_KEY-1:0]   aes_in_data,
    output logic                   aes_in_en,
    output logic [WIDTH_KEY-1:0]   encrypt_data,
    output logic                   encrypt_en,
    output logic                   busy,
    output logic                   done,
    output logic                   ctr_err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REQ,
        ISSUE,
        WAIT_AES,
        ERROR
    } state_t;

    state_t                 state, state_nxt;
    logic [WIDTH_COUNT-1:0] count, count_nxt;
    logic                   wrap, wrap_nxt;
    logic                   last_pend, last_pend_nxt;
    logic [WIDTH_NONCE-1:0] nonce_q, nonce_nxt;
    logic [WIDTH_FLAG-1:0]  flag_q, flag_nxt;
    logic [WIDTH_KEY-1:0]   aes_in_data_nxt;
    logic                   aes_in_en_nxt;
    logic [WIDTH_KEY-1:0]   encrypt_data_nxt;
    logic                   encrypt_en_nxt;
    logic                   busy_nxt;
    logic                   done_nxt;
    logic                   ctr_err_nxt;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_nxt        = state;
        count_nxt        = count;
        wrap_nxt         = wrap;
        last_pend_nxt    = last_pend;
        nonce_nxt        = nonce_q;
        flag_nxt         = flag_q;
        aes_in_data_nxt  = aes_in_data;
        aes_in_en_nxt    = 1'b0;
        encrypt_data_nxt = encrypt_data;
        encrypt_en_nxt   = 1'b0;
        busy_nxt         = busy;
        done_nxt         = 1'b0;
        ctr_err_nxt      = ctr_err;

        if (busy && last_in) begin
            last_pend_nxt = 1'b1;
        end

        unique case (state)
            IDLE, ERROR: begin
                if (start) begin
                    nonce_nxt     = nonce;
                    flag_nxt      = flag;
                    count_nxt     = WIDTH_COUNT'(1);
                    wrap_nxt      = 1'b0;
                    last_pend_nxt = 1'b0;
                    ctr_err_nxt   = 1'b0;
                    busy_nxt      = 1'b1;
                    state_nxt     = WAIT_REQ;
                end
            end
            WAIT_REQ: begin
                if (block_req) begin
                    if (wrap) begin
                        ctr_err_nxt = 1'b1;
                        state_nxt   = ERROR;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (aes_ready) begin
                    aes_in_en_nxt   = 1'b1;
                    aes_in_data_nxt = {flag_q, nonce_q, count};
                    count_nxt       = count + WIDTH_COUNT'(1);
                    // The all-ones count is the last unique counter value for this nonce.
                    if (count == '1) begin
                        wrap_nxt = 1'b1;
                    end
                    state_nxt = WAIT_AES;
                end
            end
            WAIT_AES: begin
                if (aes_out_en) begin
                    encrypt_data_nxt = aes_out_data;
                    encrypt_en_nxt   = 1'b1;
                    // last_in arriving on the delivery cycle still ends the message.
                    if (last_pend || last_in) begin
                        done_nxt      = 1'b1;
                        busy_nxt      = 1'b0;
                        last_pend_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end else begin
                        state_nxt = WAIT_REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (kill) begin
            state        <= IDLE;
            count        <= '0;
            wrap         <= 1'b0;
            last_pend    <= 1'b0;
            nonce_q      <= '0;
            flag_q       <= '0;
            aes_in_data  <= '0;
            aes_in_en    <= 1'b0;
            encrypt_data <= '0;
            encrypt_en   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ctr_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            wrap         <= wrap_nxt;
            last_pend    <= last_pend_nxt;
            nonce_q      <= nonce_nxt;
            flag_q       <= flag_nxt;
            aes_in_data  <= aes_in_data_nxt;
            aes_in_en    <= aes_in_en_nxt;
            encrypt_data <= encrypt_data_nxt;
            encrypt_en   <= encrypt_en_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            ctr_err      <= ctr_err_nxt;
        end
    end

endmodule

// File: tb/tb_ccm_ctr_block_gen.sv
// Bench for ccm_ctr_block_gen: a default-width and a 4-bit-counter instance share stimulus
// and are compared every cycle against a message-level reference model.
module tb_ccm_ctr_block_gen;

    logic         clk = 1'b0;
    logic         kill, start, block_req, last_in, aes_ready, aes_out_en;
    logic [99:0]  nonce;
    logic [7:0]   flag;
    logic [127:0] aes_out_data;

    logic [127:0] d0_aes_in_data, d0_encrypt_data;
    logic         d0_aes_in_en, d0_encrypt_en, d0_busy, d0_done, d0_ctr_err;
    logic [111:0] d1_aes_in_data, d1_encrypt_data;
    logic         d1_aes_in_en, d1_encrypt_en, d1_busy, d1_done, d1_ctr_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ccm_ctr_block_gen dut0 (
        .clk(clk), .kill(kill), .start(start), .nonce(nonce), .flag(flag),
        .block_req(block_req), .last_in(last_in), .aes_ready(aes_ready),
        .aes_out_data(aes_out_data), .aes_out_en(aes_out_en),
        .aes_in_data(d0_aes_in_data), .aes_in_en(d0_aes_in_en),
        .encrypt_data(d0_encrypt_data), .encrypt_en(d0_encrypt_en),
        .busy(d0_busy), .done(d0_done), .ctr_err(d0_ctr_err)
    );

    ccm_ctr_block_gen #(.WIDTH_COUNT(4)) dut1 (
        .clk(clk), .kill(kill), .start(start), .nonce(nonce), .flag(flag),
        .block_req(block_req), .last_in(last_in), .aes_ready(aes_ready),
        .aes_out_data(aes_out_data[111:0]), .aes_out_en(aes_out_en),
        .aes_in_data(d1_aes_in_data), .aes_in_en(d1_aes_in_en),
        .encrypt_data(d1_encrypt_data), .encrypt_en(d1_encrypt_en),
        .busy(d1_busy), .done(d1_done), .ctr_err(d1_ctr_err)
    );

    // Reference model: message-level view (active / errored / block outstanding).
    typedef struct {
        bit           busy;
        bit           err;
        bit           want_issue;
        bit           await_aes;
        bit           wrap;
        bit           lpend;
        int unsigned  cnt;
        bit [99:0]    nonce;
        bit [7:0]     flag;
        bit           aes_en;
        bit [127:0]   aes_data;
        bit           enc_en;
        bit [127:0]   enc_data;
        bit           done;
    } model_t;

    model_t m [2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            model_t      s;
            model_t      n;
            int unsigned cw;
            int unsigned kw;
            bit [127:0]  mask;
            s  = m[i];
            n  = s;
            cw = (i == 0) ? 20 : 4;
            kw = 108 + cw;
            mask = (128'(1) << kw) - 128'(1);
            n.aes_en = 1'b0;
            n.enc_en = 1'b0;
            n.done   = 1'b0;
            if (kill) begin
                n = '{default: '0};
            end else if ((!s.busy || s.err) && start) begin
                n.nonce = nonce; n.flag = flag; n.cnt = 1;
                n.wrap = 0; n.lpend = 0; n.err = 0; n.busy = 1;
                n.want_issue = 0; n.await_aes = 0;
            end else begin
                if (s.busy && last_in) n.lpend = 1'b1;
                if (s.busy && !s.err && !s.want_issue && !s.await_aes && block_req) begin
                    if (s.wrap) n.err = 1'b1;
                    else n.want_issue = 1'b1;
                end else if (s.want_issue && aes_ready) begin
                    n.aes_en   = 1'b1;
                    n.aes_data = (128'(s.flag) << (100 + cw)) | (128'(s.nonce) << cw) | 128'(s.cnt);
                    if (s.cnt == (32'd1 << cw) - 1) n.wrap = 1'b1;
                    n.cnt        = (s.cnt + 1) % (32'd1 << cw);
                    n.want_issue = 1'b0;
                    n.await_aes  = 1'b1;
                end else if (s.await_aes && aes_out_en) begin
                    n.enc_en    = 1'b1;
                    n.enc_data  = aes_out_data & mask;
                    n.await_aes = 1'b0;
                    if (s.lpend || last_in) begin
                        n.done  = 1'b1;
                        n.busy  = 1'b0;
                        n.lpend = 1'b0;
                    end
                end
            end
            m[i] = n;
        end
    endtask

    task automatic compare_all();
        check("d0 aes_in_en",    128'(d0_aes_in_en),    128'(m[0].aes_en));
        check("d0 aes_in_data",  d0_aes_in_data,        m[0].aes_data);
        check("d0 encrypt_en",   128'(d0_encrypt_en),   128'(m[0].enc_en));
        check("d0 encrypt_data", d0_encrypt_data,       m[0].enc_data);
        check("d0 busy",         128'(d0_busy),         128'(m[0].busy));
        check("d0 done",         128'(d0_done),         128'(m[0].done));
        check("d0 ctr_err",      128'(d0_ctr_err),      128'(m[0].err));
        check("d1 aes_in_en",    128'(d1_aes_in_en),    128'(m[1].aes_en));
        check("d1 aes_in_data",  128'(d1_aes_in_data),  m[1].aes_data);
        check("d1 encrypt_en",   128'(d1_encrypt_en),   128'(m[1].enc_en));
        check("d1 encrypt_data", 128'(d1_encrypt_data), m[1].enc_data);
        check("d1 busy",         128'(d1_busy),         128'(m[1].busy));
        check("d1 done",         128'(d1_done),         128'(m[1].done));
        check("d1 ctr_err",      128'(d1_ctr_err),      128'(m[1].err));
    endtask

    // Advance one edge, update the model with the inputs seen at that edge, then compare.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        kill = 0; start = 0; block_req = 0; last_in = 0; aes_ready = 0; aes_out_en = 0;
    endtask

    task automatic do_start(input logic [99:0] nv, input logic [7:0] fv);
        start = 1; nonce = nv; flag = fv;
        tick();
        start = 0;
    endtask

    task automatic do_block(input logic last);
        block_req = 1; last_in = last;
        tick();
        block_req = 0; last_in = 0; aes_ready = 1;
        tick();
        aes_ready = 0; aes_out_en = 1;
        aes_out_data = {$urandom, $urandom, $urandom, $urandom};
        tick();
        aes_out_en = 0;
        tick();
    endtask

    task automatic do_kill();
        clear_inputs();
        kill = 1;
        tick();
        tick();
        kill = 0;
    endtask

    initial begin
        logic [127:0] r;
        clear_inputs();
        nonce = '0; flag = '0; aes_out_data = '0;
        for (int i = 0; i < 2; i++) m[i] = '{default: '0};

        // Reset
        do_kill();
        check("reset busy", 128'(d0_busy), 128'(0));
        check("reset aes_in_data", d0_aes_in_data, 128'(0));

        // Single block
        do_start(100'h1, 8'h01);
        block_req = 1;
        tick();
        block_req = 0; aes_ready = 1;
        tick();
        check("single aes_in_en", 128'(d0_aes_in_en), 128'(1));
        check("single aes_in_data", d0_aes_in_data, {8'h01, 100'h1, 20'h00001});
        aes_ready = 0; aes_out_en = 1; aes_out_data = {16{8'hA5}};
        tick();
        check("single encrypt_en", 128'(d0_encrypt_en), 128'(1));
        check("single encrypt_data", d0_encrypt_data, {16{8'hA5}});
        aes_out_en = 0;
        tick();

        // Three blocks, last_in with the third request
        do_kill();
        do_start(100'h123456789ABCDEF, 8'h5A);
        do_block(0);
        do_block(0);
        block_req = 1; last_in = 1;
        tick();
        block_req = 0; last_in = 0; aes_ready = 1;
        tick();
        check("three count3", 128'(d0_aes_in_data[19:0]), 128'(3));
        aes_ready = 0; aes_out_en = 1; aes_out_data = 128'hDEAD_BEEF;
        tick();
        check("three done", 128'(d0_done), 128'(1));
        check("three busy", 128'(d0_busy), 128'(0));
        aes_out_en = 0;
        tick();

        // Backpressure
        do_start(100'h77, 8'h33);
        block_req = 1;
        tick();
        block_req = 0;
        for (int k = 0; k < 5; k++) tick();
        aes_ready = 1;
        tick();
        check("bp pulse", 128'(d0_aes_in_en), 128'(1));
        check("bp count", 128'(d0_aes_in_data[19:0]), 128'(1));
        tick();
        check("bp single pulse", 128'(d0_aes_in_en), 128'(0));
        aes_ready = 0; aes_out_en = 1;
        tick();
        aes_out_en = 0;
        do_block(1);

        // Counter exhaustion on the 4-bit instance
        do_kill();
        do_start(100'hABC, 8'h0F);
        for (int k = 0; k < 15; k++) do_block(0);
        block_req = 1;
        tick();
        block_req = 0;
        check("exhaust ctr_err", 128'(d1_ctr_err), 128'(1));
        aes_ready = 1;
        tick();
        check("exhaust no issue", 128'(d1_aes_in_en), 128'(0));
        aes_ready = 0;
        do_start(100'h1, 8'h02);
        check("exhaust cleared", 128'(d1_ctr_err), 128'(0));
        check("exhaust busy", 128'(d1_busy), 128'(1));

        // Kill in WAIT_AES
        do_kill();
        do_start(100'h5, 8'h06);
        block_req = 1;
        tick();
        block_req = 0; aes_ready = 1;
        tick();
        aes_ready = 0; kill = 1;
        tick();
        kill = 0; aes_out_en = 1;
        tick();
        check("kill no encrypt_en", 128'(d0_encrypt_en), 128'(0));
        check("kill busy", 128'(d0_busy), 128'(0));
        aes_out_en = 0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            kill      = ($urandom_range(0, 99) < 2);
            start     = ($urandom_range(0, 99) < 8);
            block_req = ($urandom_range(0, 99) < 30);
            last_in   = ($urandom_range(0, 99) < 10);
            aes_ready = ($urandom_range(0, 99) < 60);
            aes_out_en = ($urandom_range(0, 99) < 40);
            r = {$urandom, $urandom, $urandom, $urandom};
            nonce = r[99:0];
            flag  = 8'($urandom);
            aes_out_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
